// File: rtl/spike_synapse_if.sv
// Signal bundle between the synapse front end and its driver.
// Carries spikes, weight writes and the current fed to the lif neuron.
interface spike_synapse_if #(
    parameter int NUM_IN = 4,
    parameter int AW     = $clog2(NUM_IN)
);
    logic [NUM_IN-1:0] pre_spike;
    logic              post_spike;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        current;
    logic              refractory;
    logic              sat;

    modport master (
        output pre_spike,
        output post_spike,
        output wr_en,
        output wr_addr,
        output wr_data,
        input  current,
        input  refractory,
        input  sat
    );

    modport slave (
        input  pre_spike,
        input  post_spike,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output current,
        output refractory,
        output sat
    );
endinterface

// File: rtl/spike_synapse.sv
// Weighted spike accumulator with exponential decay and saturation.
// A post-synaptic spike clears the current and opens a refractory window.
module spike_synapse #(
    parameter int NUM_IN      = 4,
    parameter int DECAY_SHIFT = 2,
    parameter int REFRAC      = 4,
    parameter int W_INIT      = 40
) (
    input  logic           clk,
    input  logic           rst,
    spike_synapse_if.slave bus
);
    localparam int AW = $clog2(NUM_IN);
    localparam int SW = 8 + AW;
    localparam int NW = SW + 2;

    logic [7:0]    w_q [NUM_IN];
    logic [7:0]    cur_q;
    logic [7:0]    cur_d;
    logic          sat_q;
    logic          sat_d;
    logic [7:0]    cnt_q;
    logic [7:0]    cnt_d;
    logic [7:0]    dec;
    logic [SW-1:0] sum;
    logic [NW-1:0] nxt;

    // Minimum decay of one so small residues still drain to zero.
    always_comb begin
        dec = cur_q >> DECAY_SHIFT;
        if (dec == 8'd0 && cur_q != 8'd0) begin
            dec = 8'd1;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.pre_spike[i]) begin
                sum = sum + SW'(w_q[i]);
            end
        end
    end

    assign nxt = NW'(cur_q) - NW'(dec) + NW'(sum);

    always_comb begin
        cur_d = cur_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        priority case (1'b1)
            bus.post_spike: begin
                cur_d = 8'd0;
                sat_d = 1'b0;
                cnt_d = 8'(REFRAC);
            end
            (cnt_q != 8'd0): begin
                cur_d = 8'd0;
                sat_d = 1'b0;
                cnt_d = cnt_q - 8'd1;
            end
            default: begin
                if (nxt > NW'(255)) begin
                    cur_d = 8'hff;
                    sat_d = 1'b1;
                end else begin
                    cur_d = nxt[7:0];
                    sat_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= 8'd0;
            sat_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            cur_q <= cur_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    // Write lands after this edge's sum, so a same-cycle spike sees the old weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                w_q[i] <= 8'(W_INIT);
            end
        end else if (bus.wr_en) begin
            w_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.current    = cur_q;
    assign bus.sat        = sat_q;
    assign bus.refractory = (cnt_q != 8'd0);
endmodule

// File: tb/tb_spike_synapse.sv
// Scoreboard bench for spike_synapse: a cycle model pushes expectations,
// which are popped and compared one cycle after each driven edge.
module tb_spike_synapse;
    localparam int NI = 4;
    localparam int DS = 2;
    localparam int RF = 4;
    localparam int WI = 40;

    typedef struct {
        int cur;
        int sat;
        int refr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb [$];

    int m_cur;
    int m_sat;
    int m_cnt;
    int m_w [NI];

    spike_synapse_if #(.NUM_IN(NI)) bus ();

    spike_synapse #(
        .NUM_IN(NI),
        .DECAY_SHIFT(DS),
        .REFRAC(RF),
        .W_INIT(WI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got,
                         input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_cur = 0;
        m_sat = 0;
        m_cnt = 0;
        for (int i = 0; i < NI; i++) m_w[i] = WI;
    endtask

    task automatic drive(input logic [NI-1:0] pre, input logic post,
                         input logic we, input int wa, input int wd);
        int   sum;
        int   dec;
        int   n;
        exp_t e;
        bus.pre_spike  = pre;
        bus.post_spike = post;
        bus.wr_en      = we;
        bus.wr_addr    = 2'(wa);
        bus.wr_data    = 8'(wd);
        sum = 0;
        for (int i = 0; i < NI; i++) if (pre[i]) sum += m_w[i];
        dec = m_cur >> DS;
        if (dec == 0 && m_cur > 0) dec = 1;
        if (post) begin
            m_cur = 0;
            m_sat = 0;
            m_cnt = RF;
        end else if (m_cnt > 0) begin
            m_cur = 0;
            m_sat = 0;
            m_cnt--;
        end else begin
            n = m_cur - dec + sum;
            m_sat = (n > 255) ? 1 : 0;
            m_cur = (n > 255) ? 255 : n;
        end
        if (we) m_w[wa] = wd;
        sb.push_back('{m_cur, m_sat, (m_cnt != 0) ? 1 : 0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cur", int'(bus.current), e.cur);
        check("sat", int'(bus.sat), e.sat);
        check("refr", int'(bus.refractory), e.refr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int decay_tbl [15];
        int hi;
        decay_tbl = '{40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
        bus.pre_spike  = '0;
        bus.post_spike = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cur", int'(bus.current), 0);
        check("rst_sat", int'(bus.sat), 0);
        check("rst_refr", int'(bus.refractory), 0);
        #2 rst = 1'b0;

        drive(4'b0001, 1'b0, 1'b0, 0, 0);
        check("decay0", int'(bus.current), decay_tbl[0]);
        for (int i = 1; i < 15; i++) begin
            idle(1);
            check($sformatf("decay%0d", i), int'(bus.current),
                  decay_tbl[i]);
            check("decay_sat", int'(bus.sat), 0);
        end
        idle(2);
        check("decay_hold", int'(bus.current), 0);

        drive(4'b1111, 1'b0, 1'b0, 0, 0);
        check("sat_160", int'(bus.current), 160);
        drive(4'b1111, 1'b0, 1'b0, 0, 0);
        check("sat_255", int'(bus.current), 255);
        check("sat_flag", int'(bus.sat), 1);
        drive(4'b1111, 1'b0, 1'b0, 0, 0);
        check("sat_hold", int'(bus.current), 255);
        check("sat_flag_hold", int'(bus.sat), 1);
        idle(1);
        check("sat_rel", int'(bus.current), 192);
        check("sat_clr", int'(bus.sat), 0);
        idle(30);

        drive(4'b0100, 1'b0, 1'b1, 2, 100);
        check("wr_old", int'(bus.current), 40);
        idle(20);
        drive(4'b0100, 1'b0, 1'b0, 0, 0);
        check("wr_new", int'(bus.current), 100);
        idle(25);

        drive('0, 1'b0, 1'b1, 3, 200);
        drive(4'b1000, 1'b0, 1'b0, 0, 0);
        check("ref_200", int'(bus.current), 200);
        drive(4'b1111, 1'b1, 1'b0, 0, 0);
        check("ref_clr", int'(bus.current), 0);
        hi = 0;
        if (bus.refractory) hi++;
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 1'b0, 1'b0, 0, 0);
            check("ref_cur0", int'(bus.current), 0);
            if (bus.refractory) hi++;
        end
        check("ref_len", hi, 4);
        drive(4'b0001, 1'b0, 1'b0, 0, 0);
        check("ref_after", int'(bus.current), 40);
        idle(20);

        drive(4'b0001, 1'b1, 1'b0, 0, 0);
        check("sim_cur", int'(bus.current), 0);
        check("sim_refr", int'(bus.refractory), 1);
        idle(1);
        drive('0, 1'b1, 1'b0, 0, 0);
        hi = 0;
        if (bus.refractory) hi++;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (bus.refractory) hi++;
        end
        check("sim_ext", hi, 4);
        idle(2);

        drive('0, 1'b0, 1'b1, 3, 80);
        drive('0, 1'b0, 1'b1, 1, 7);
        drive(4'b1001, 1'b0, 1'b0, 0, 0);
        check("ar_120", int'(bus.current), 120);
        bus.pre_spike = '0;
        #3 rst = 1'b1;
        #1;
        check("ar_cur", int'(bus.current), 0);
        check("ar_refr", int'(bus.refractory), 0);
        model_reset();
        #2 rst = 1'b0;
        drive(4'b0010, 1'b0, 1'b0, 0, 0);
        check("ar_w1", int'(bus.current), 40);

        for (int i = 0; i < 300; i++) begin
            drive(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)));
        end
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
- Synaptic front end that sits directly upstream of the lif neuron and drives its 8-bit current input.
- Accepts NUM_IN presynaptic spike lines, each with a programmable 8-bit weight.
- Maintains an exponentially decaying, saturating current accumulator.
- Takes the neuron's output spike as post_spike; this clears the current and blocks input for a refractory window.

Parameters:
- NUM_IN, 4, number of presynaptic inputs (power of two, 2..16)
- DECAY_SHIFT, 2, decay per cycle is cur >> DECAY_SHIFT
- REFRAC, 4, refractory length in cycles after post_spike (0..255)
- W_INIT, 40, reset value of every weight register

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- pre_spike  input  NUM_IN  presynaptic spikes, sampled every rising edge
- post_spike  input  1  spike from downstream lif
- wr_en  input  1  weight write strobe
- wr_addr  input  log2(NUM_IN)  weight index to write
- wr_data  input  8  weight value to write
- current  output  8  registered synaptic current, feeds lif current
- refractory  output  1  high while the refractory counter is non-zero
- sat  output  1  registered; high for the cycle after an update saturated

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - current=0, refractory=0, sat=0, refractory counter=0.
  - All weights are set to W_INIT.
- Weight write:
  - wr_en=1 at an edge sets weight[wr_addr] <= wr_data.
  - The new value is used from the next edge onward.
  - A spike on the same channel in the same cycle uses the old weight.
- Normal update (refractory counter=0 and post_spike=0), each edge:
  - dec = cur >> DECAY_SHIFT. If that is 0 and cur != 0, dec = 1, so the current always decays to 0.
  - sum = sum of weight[i] for every i with pre_spike[i]=1. Width: 8+log2(NUM_IN) bits, no loss.
  - nxt = cur - dec + sum, computed at 10+ bits.
  - If nxt > 255: current <= 255 and sat <= 1. Otherwise current <= nxt and sat <= 0.
- Latency: one cycle. A spike sampled at edge k is reflected in current after edge k.
- post_spike=1 at an edge, in any state, has highest priority:
  - current <= 0, sat <= 0.
  - Refractory counter <= REFRAC.
  - Same-cycle pre_spike contributions are discarded.
  - A post_spike during refractory reloads the counter to REFRAC.
- Refractory (counter > 0 and post_spike=0), each edge:
  - current held at 0, pre_spike ignored, sat=0.
  - Counter decrements by 1.
- refractory output = (counter != 0), taken directly from the counter register.
- REFRAC=0: post_spike clears current for that edge only. refractory never asserts, and input is accepted on the next edge.
- Weight writes are accepted during refractory.
- Reset mid-operation discards the accumulator and any pending refractory count.

Test Plan:
- Decay after reset: single pre_spike[0] pulse -> current 40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0, then holds 0, sat=0 throughout.
- Saturation: pre_spike=4'b1111 held with all weights 40 -> current 160, then 255 with sat=1 the same cycle. Current stays 255 and sat stays 1 while held. Releasing the input -> 192 with sat=0.
- Write hazard: wr_en=1, wr_addr=2, wr_data=100 with pre_spike[2]=1 at the same edge -> current 40. Let it decay to 0, then pulse pre_spike[2] -> current 100.
- Refractory: build current to 200, pulse post_spike -> current 0 and refractory=1 for 4 edges while pre_spike=4'b1111 is driven (current stays 0). refractory=0 afterward. Then pre_spike[0] -> current 40.
- Simultaneous events: post_spike=1 and pre_spike=4'b0001 at the same edge -> current 0 and refractory=1. A post_spike 2 cycles later -> refractory is extended to a full 4 further cycles.
- Async reset: assert rst between edges with current=120 and weight[1]=7 -> current 0 and refractory 0 before the next edge. After release, pre_spike[1] -> current 40 (weight back to W_INIT).
